// File: rtl/fetch_unit_pkg.sv
// Shared constants for the fetch stage: opcode/func codes, jump encodings,
// fetch FSM states and instruction field positions.
package fetch_unit_pkg;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int FUNC_MSB  = 3;
  localparam int FUNC_LSB  = 0;
  localparam int JADDR_W   = 12;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_J     = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_BNE   = 4'h6;

  localparam logic [3:0] FUNC_ADD = 4'h0;
  localparam logic [3:0] FUNC_SUB = 4'h1;
  localparam logic [3:0] FUNC_AND = 4'h2;
  localparam logic [3:0] FUNC_OR  = 4'h3;
  localparam logic [3:0] FUNC_JR  = 4'h8;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_J    = 2'b01,
    JMP_JR   = 2'b10,
    JMP_RSVD = 2'b11
  } jump_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the fetch stage.
interface fetch_unit_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    // req rises with a stable addr and is held until a one-cycle ack pulse,
    // which carries rdata; ack seen while req is low is meaningless.
    logic          req;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          ack;

    modport master (output req, output addr, input rdata, input ack);
    modport slave  (input req, input addr, output rdata, output ack);
endinterface

// File: rtl/fetch_unit_pc_next_sel.sv
// Combinational next-PC selection: sequential increment and redirect target
// with priority jr > j > taken branch.
import fetch_unit_pkg::*;

module fetch_unit_pc_next_sel #(
    parameter int AW     = 16,
    parameter int BOFF_W = 8
) (
    input  logic [AW-1:0]      pc,
    input  logic [JADDR_W-1:0] ir_low,
    input  logic [1:0]         jump,
    input  logic               branch,
    input  logic               bne_or_beq,
    input  logic               zero,
    input  logic [AW-1:0]      alu_out,
    output logic [AW-1:0]      pc_inc,
    output logic [AW-1:0]      redirect_pc,
    output logic               redirect
);
    logic [AW-1:0] boff_sext;
    logic          taken;

    assign pc_inc    = pc + AW'(1);
    assign boff_sext = {{(AW-BOFF_W){ir_low[BOFF_W-1]}}, ir_low[BOFF_W-1:0]};
    assign taken     = branch & (zero ^ bne_or_beq);

    always_comb begin
        redirect_pc = pc;
        redirect    = 1'b0;
        if (jump_t'(jump) == JMP_JR) begin
            redirect_pc = alu_out;
            redirect    = 1'b1;
        end else if (jump_t'(jump) == JMP_J) begin
            // Page-relative: upper PC bits are kept, low 12 come from the IR.
            redirect_pc = {pc[AW-1:JADDR_W], ir_low};
            redirect    = 1'b1;
        end else if (taken) begin
            redirect_pc = pc + boff_sext;
            redirect    = 1'b1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC and IR registers, memory req/ack FSM and
// redirect handling for beq/bne, j and jr.
import fetch_unit_pkg::*;

module fetch_unit #(
    parameter int          DW       = 16,
    parameter int          AW       = 16,
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          BOFF_W   = 8
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                PCwrt,
    input  logic                IRwrt,
    input  logic                branch,
    input  logic                BNEoBEQ,
    input  logic [1:0]          jump,
    input  logic                zero,
    input  logic [AW-1:0]       alu_out,
    fetch_unit_if.master        imem,
    output logic [DW-1:0]       ir,
    output logic [3:0]          op,
    output logic [3:0]          func,
    output logic [AW-1:0]       pc,
    output logic                fetch_busy,
    output logic                ir_valid,
    output logic                redir_err,
    output fetch_state_t        dbg_state
);
    fetch_state_t  state, next_state;
    logic          fetch_start;
    logic          fetch_done;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic [AW-1:0] pc_inc;

    fetch_unit_pc_next_sel #(.AW(AW), .BOFF_W(BOFF_W)) u_pc_next_sel (
        .pc          (pc),
        .ir_low      (ir[JADDR_W-1:0]),
        .jump        (jump),
        .branch      (branch),
        .bne_or_beq  (BNEoBEQ),
        .zero        (zero),
        .alu_out     (alu_out),
        .pc_inc      (pc_inc),
        .redirect_pc (redirect_pc),
        .redirect    (redirect)
    );

    always_ff @(posedge CLK) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state  = state;
        fetch_start = 1'b0;
        fetch_done  = 1'b0;
        case (state)
            S_IDLE: begin
                fetch_start = PCwrt & IRwrt;
                if (fetch_start) next_state = S_WAIT;
            end
            S_WAIT: begin
                fetch_done = imem.ack;
                if (fetch_done) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // A redirect arriving with a fetch strobe is dropped and flagged sticky.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc        <= AW'(RESET_PC);
            ir        <= '0;
            imem.req  <= 1'b0;
            imem.addr <= '0;
            ir_valid  <= 1'b0;
            redir_err <= 1'b0;
        end else if (fetch_start) begin
            imem.req  <= 1'b1;
            imem.addr <= pc;
            if (redirect) redir_err <= 1'b1;
        end else if (state == S_IDLE && redirect) begin
            pc <= redirect_pc;
        end else if (fetch_done) begin
            ir       <= imem.rdata;
            pc       <= pc_inc;
            ir_valid <= 1'b1;
            imem.req <= 1'b0;
        end
    end

    assign op         = ir[OP_MSB:OP_LSB];
    assign func       = ir[FUNC_MSB:FUNC_LSB];
    assign fetch_busy = (state == S_WAIT);
    assign dbg_state  = state;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of fetches and redirects plus
// hand sequences for strobe/redirect collision, stalls and reset mid-fetch.
import fetch_unit_pkg::*;

module tb_fetch_unit;
  logic        CLK;
  logic        reset;
  logic        PCwrt, IRwrt, branch, BNEoBEQ, zero;
  logic [1:0]  jump;
  logic [15:0] alu_out;
  logic [15:0] ir, pc;
  logic [3:0]  op, func;
  logic        fetch_busy, ir_valid, redir_err;
  fetch_state_t dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit_if #(.AW(16), .DW(16)) imem ();

  fetch_unit dut (
    .CLK(CLK), .reset(reset), .PCwrt(PCwrt), .IRwrt(IRwrt),
    .branch(branch), .BNEoBEQ(BNEoBEQ), .jump(jump), .zero(zero),
    .alu_out(alu_out), .imem(imem.master), .ir(ir), .op(op), .func(func),
    .pc(pc), .fetch_busy(fetch_busy), .ir_valid(ir_valid),
    .redir_err(redir_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    PCwrt = 0; IRwrt = 0; branch = 0; BNEoBEQ = 0; zero = 0;
    jump = 2'b00; alu_out = 16'h0;
  endtask

  // driver: full fetch with `delay` extra wait cycles before ack
  task automatic do_fetch(input logic [15:0] rdata, input int delay,
                          input logic [15:0] exp_pc, input logic [15:0] prev_ir);
    logic [15:0] start_pc;
    start_pc = pc;
    PCwrt = 1; IRwrt = 1;
    @(posedge CLK); @(negedge CLK);
    PCwrt = 0; IRwrt = 0;
    check("req_after_strobe", imem.req, 1);
    check("addr_after_strobe", imem.addr, start_pc);
    check("busy_after_strobe", fetch_busy, 1);
    check("state_wait", dbg_state, S_WAIT);
    for (int i = 0; i < delay; i++) begin
      @(posedge CLK); @(negedge CLK);
      check("req_held", imem.req, 1);
      check("addr_held", imem.addr, start_pc);
      check("busy_held", fetch_busy, 1);
      check("ir_unchanged", ir, prev_ir);
    end
    imem.ack = 1; imem.rdata = rdata;
    @(posedge CLK); @(negedge CLK);
    imem.ack = 0; imem.rdata = 16'hDEAD;
    check("req_dropped", imem.req, 0);
    check("busy_dropped", fetch_busy, 0);
    check("ir_valid", ir_valid, 1);
  endtask

  task automatic do_redirect(input logic [1:0] j, input logic br, input logic bne,
                             input logic z, input logic [15:0] alu);
    jump = j; branch = br; BNEoBEQ = bne; zero = z; alu_out = alu;
    @(posedge CLK); @(negedge CLK);
    idle_inputs();
    check("busy_redirect", fetch_busy, 0);
  endtask

  typedef struct {
    logic        is_fetch;
    logic [15:0] rdata;
    int          delay;
    logic [1:0]  jump;
    logic        branch;
    logic        bne;
    logic        zero;
    logic [15:0] alu;
    logic [15:0] exp_pc;
    logic [15:0] exp_ir;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t fv(input logic [15:0] rd, input int d, input logic [15:0] epc);
    vec_t v;
    v = '{1'b1, rd, d, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0, epc, rd};
    return v;
  endfunction

  function automatic vec_t rv(input logic [1:0] j, input logic br, input logic bne,
                              input logic z, input logic [15:0] alu,
                              input logic [15:0] epc, input logic [15:0] eir);
    vec_t v;
    v = '{1'b0, 16'h0, 0, j, br, bne, z, alu, epc, eir};
    return v;
  endfunction

  initial begin
    logic [15:0] cur_ir;
    vecs[0]  = fv(16'h1234, 0, 16'h0001);
    vecs[1]  = fv(16'h5678, 5, 16'h0002);
    vecs[2]  = rv(2'b10, 0, 0, 0, 16'h000F, 16'h000F, 16'h5678);
    vecs[3]  = fv(16'h00FC, 0, 16'h0010);
    vecs[4]  = rv(2'b00, 1, 0, 1, 16'h0,    16'h000C, 16'h00FC);
    vecs[5]  = rv(2'b10, 0, 0, 0, 16'h0010, 16'h0010, 16'h00FC);
    vecs[6]  = rv(2'b00, 1, 0, 0, 16'h0,    16'h0010, 16'h00FC);
    vecs[7]  = rv(2'b00, 1, 1, 0, 16'h0,    16'h000C, 16'h00FC);
    vecs[8]  = rv(2'b00, 1, 1, 1, 16'h0,    16'h000C, 16'h00FC);
    vecs[9]  = rv(2'b10, 0, 0, 0, 16'h1004, 16'h1004, 16'h00FC);
    vecs[10] = fv(16'h4ABC, 0, 16'h1005);
    vecs[11] = rv(2'b01, 0, 0, 0, 16'h0,    16'h1ABC, 16'h4ABC);
    vecs[12] = rv(2'b10, 0, 0, 0, 16'h0777, 16'h0777, 16'h4ABC);
    vecs[13] = rv(2'b10, 1, 0, 1, 16'h0123, 16'h0123, 16'h4ABC);
    vecs[14] = rv(2'b01, 1, 0, 1, 16'h0,    16'h0ABC, 16'h4ABC);
    vecs[15] = rv(2'b11, 0, 0, 0, 16'h0,    16'h0ABC, 16'h4ABC);
    vecs[16] = rv(2'b10, 0, 0, 0, 16'hFFFF, 16'hFFFF, 16'h4ABC);
    vecs[17] = fv(16'h9003, 2, 16'h0000);
    vecs[18] = rv(2'b00, 1, 0, 1, 16'h0,    16'h0003, 16'h9003);
    vecs[19] = rv(2'b10, 0, 0, 0, 16'hFFFE, 16'hFFFE, 16'h9003);
    vecs[20] = fv(16'h1105, 1, 16'hFFFF);
    vecs[21] = rv(2'b00, 1, 0, 1, 16'h0,    16'h0004, 16'h1105);
    vecs[22] = rv(2'b00, 0, 0, 1, 16'h0,    16'h0004, 16'h1105);

    idle_inputs();
    imem.ack = 0; imem.rdata = 16'h0;
    reset = 1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    reset = 0;
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", ir, 16'h0000);
    check("rst_req", imem.req, 0);
    check("rst_busy", fetch_busy, 0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_redir_err", redir_err, 0);
    check("rst_state", dbg_state, S_IDLE);

    cur_ir = 16'h0000;
    for (int i = 0; i < 23; i++) begin
      if (vecs[i].is_fetch) do_fetch(vecs[i].rdata, vecs[i].delay, vecs[i].exp_pc, cur_ir);
      else do_redirect(vecs[i].jump, vecs[i].branch, vecs[i].bne, vecs[i].zero, vecs[i].alu);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_ir", i), ir, vecs[i].exp_ir);
      check($sformatf("vec%0d_op", i), op, vecs[i].exp_ir >> 12);
      check($sformatf("vec%0d_func", i), func, vecs[i].exp_ir & 16'h000F);
      cur_ir = vecs[i].exp_ir;
    end
    check("no_redir_err_yet", redir_err, 0);

    // control strobes during S_WAIT are ignored
    PCwrt = 1; IRwrt = 1;
    @(posedge CLK); @(negedge CLK);
    jump = 2'b10; alu_out = 16'h5555; branch = 1; zero = 1;
    repeat (2) begin
      @(posedge CLK); @(negedge CLK);
      check("wait_addr_held", imem.addr, 16'h0004);
      check("wait_pc_held", pc, 16'h0004);
    end
    idle_inputs();
    imem.ack = 1; imem.rdata = 16'h2222;
    @(posedge CLK); @(negedge CLK);
    imem.ack = 0;
    check("wait_ignore_pc", pc, 16'h0005);
    check("wait_ignore_ir", ir, 16'h2222);
    check("wait_ignore_err", redir_err, 0);

    // fetch strobe with simultaneous j: fetch wins, sticky error
    PCwrt = 1; IRwrt = 1; jump = 2'b01;
    @(posedge CLK); @(negedge CLK);
    idle_inputs();
    check("coll_addr", imem.addr, 16'h0005);
    check("coll_pc", pc, 16'h0005);
    check("coll_err", redir_err, 1);
    imem.ack = 1; imem.rdata = 16'h3333;
    @(posedge CLK); @(negedge CLK);
    imem.ack = 0;
    check("coll_pc_after", pc, 16'h0006);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("coll_err_sticky", redir_err, 1);

    // stray ack while idle is ignored
    imem.ack = 1; imem.rdata = 16'h7777;
    @(posedge CLK); @(negedge CLK);
    imem.ack = 0;
    check("stray_ack_ir", ir, 16'h3333);
    check("stray_ack_pc", pc, 16'h0006);

    // reset while a fetch is outstanding, then a late ack
    PCwrt = 1; IRwrt = 1;
    @(posedge CLK); @(negedge CLK);
    idle_inputs();
    check("pre_rst_busy", fetch_busy, 1);
    reset = 1;
    @(posedge CLK); @(negedge CLK);
    reset = 0;
    imem.ack = 1; imem.rdata = 16'hBEEF;
    @(posedge CLK); @(negedge CLK);
    imem.ack = 0;
    check("late_ack_ir", ir, 16'h0000);
    check("late_ack_ir_valid", ir_valid, 0);
    check("late_ack_pc", pc, 16'h0000);
    check("late_ack_req", imem.req, 0);
    check("late_ack_state", dbg_state, S_IDLE);
    check("late_ack_err_cleared", redir_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
